// File: rtl/sync_debounce.sv
// Debounce and edge-detect stage for an already-synchronized single-bit level.
// The output level flips only after DebounceCycles consecutive differing samples.
module sync_debounce #(
   parameter int unsigned DebounceCycles = 16,
   parameter logic        ResetValue     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic serial_i,
   output logic serial_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);
   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DebounceCycles - 1);

   if (DebounceCycles == 0) begin : g_bad_cycles
      $error("sync_debounce: DebounceCycles must be at least 1");
   end

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_t;

   state_t              state;
   logic [CntWidth-1:0] cnt;
   logic                diff;

   assign diff = serial_i ^ serial_o;

   // Qualification FSM; pulses are cleared every cycle unless a flip is taken.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= STABLE;
         cnt      <= '0;
         serial_o <= ResetValue;
         rise_o   <= 1'b0;
         fall_o   <= 1'b0;
         busy_o   <= 1'b0;
      end else if (!en_i) begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         case (state)
            STABLE: begin
               if (!diff) begin
                  cnt <= '0;
               end else if (DebounceCycles == 1) begin
                  serial_o <= serial_i;
                  rise_o   <= serial_i;
                  fall_o   <= ~serial_i;
                  cnt      <= '0;
               end else begin
                  cnt    <= CntWidth'(1);
                  state  <= CHECK;
                  busy_o <= 1'b1;
               end
            end
            CHECK: begin
               if (!diff) begin
                  // Input bounced back: abandon the candidate silently.
                  cnt    <= '0;
                  state  <= STABLE;
                  busy_o <= 1'b0;
               end else if (cnt == LastCnt) begin
                  serial_o <= serial_i;
                  rise_o   <= serial_i;
                  fall_o   <= ~serial_i;
                  cnt      <= '0;
                  state    <= STABLE;
                  busy_o   <= 1'b0;
               end else begin
                  cnt <= cnt + CntWidth'(1);
               end
            end
            default: begin
               cnt    <= '0;
               state  <= STABLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
